// File: rtl/seq_sched_pkg.sv
// rtl/seq_sched_pkg.sv - shared states, widths and helpers for the sequence-detect scheduler
package seq_sched_pkg;

  localparam int PAT_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Round-robin between two requesters: on contention the one not served last wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_id);
    if (req == 2'b11) return ~last_id;
    return req[1];
  endfunction

  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pat3_detect.sv
// rtl/pat3_detect.sv - programmable 3-bit overlapping Moore sequence detector
module pat3_detect
  import seq_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             x,
  input  logic [PAT_W-1:0] pat,
  output logic             z
);

  logic [PAT_W-1:0] hist;
  logic [1:0]       fill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else begin
      hist <= {hist[PAT_W-2:0], x};
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end

  // Oldest bit sits in hist[2], matching pat[2] as the first pattern bit.
  assign z = (fill == 2'd3) && (hist == pat);

endmodule

// File: rtl/seq_detect_sched.sv
// rtl/seq_detect_sched.sv - round-robin sharing of one pattern detector between two framed requesters
module seq_detect_sched
  import seq_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [PAT_W-1:0] pat0,
  input  logic [PAT_W-1:0] pat1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [CNT_W-1:0] match_cnt,
  output logic             z
);

  localparam int BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [PAT_W-1:0] patreg;
  logic [BC_W-1:0]  bitcnt;
  logic [CNT_W-1:0] cnt_q;
  logic             cur_id, last_id, done_id_q;
  logic             winner, det_clr, det_z, counting;

  assign winner = rr_pick(req, last_id);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt       = 2'b00;
    busy      = 1'b1;
    done      = 1'b0;
    det_clr   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (|req) state_nxt = LOAD;
      end
      LOAD: begin
        gnt       = id_onehot(cur_id);
        det_clr   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (bitcnt == '0) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FLUSH is counted too: it carries the z produced by the final shifted bit.
  assign counting = (state == SHIFT) || (state == FLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      patreg    <= '0;
      bitcnt    <= '0;
      cnt_q     <= '0;
      cur_id    <= 1'b0;
      last_id   <= 1'b1;
      done_id_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            cur_id  <= winner;
            last_id <= winner;
            shreg   <= winner ? data1 : data0;
            patreg  <= winner ? pat1 : pat0;
          end
        end
        LOAD: begin
          cnt_q  <= '0;
          bitcnt <= BC_W'(WIDTH - 1);
        end
        SHIFT: begin
          shreg  <= {shreg[WIDTH-2:0], 1'b0};
          bitcnt <= bitcnt - BC_W'(1);
        end
        FLUSH: done_id_q <= cur_id;
        default: ;
      endcase
      if (counting && det_z && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  pat3_detect u_det (
    .clk (clk),
    .rst (rst),
    .clr (det_clr),
    .x   (shreg[WIDTH-1]),
    .pat (patreg),
    .z   (det_z)
  );

  assign match_cnt = cnt_q;
  assign done_id   = done_id_q;
  assign z         = det_z;

endmodule

// File: tb/tb_seq_detect_sched.sv
// tb/tb_seq_detect_sched.sv - directed scoreboard bench for seq_detect_sched
module tb_seq_detect_sched;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req = 2'b00;
  logic [WIDTH-1:0] data0 = '0, data1 = '0;
  logic [2:0]       pat0 = '0, pat1 = '0;
  logic [1:0]       gnt;
  logic             busy, done, done_id, z;
  logic [CNT_W-1:0] match_cnt;

  int checks = 0, errors = 0, cyc = 0, ndone = 0, prev_done = -1;
  bit chk_period = 1'b0;

  typedef struct {
    logic             id;
    logic [CNT_W-1:0] cnt;
  } exp_t;
  exp_t exp_q[$];
  int   gcyc_q[$];

  seq_detect_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
    .pat0(pat0), .pat1(pat1), .gnt(gnt), .busy(busy), .done(done),
    .done_id(done_id), .match_cnt(match_cnt), .z(z)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [CNT_W-1:0] model(input logic [WIDTH-1:0] d, input logic [2:0] p);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = WIDTH - 1; i >= 2; i--)
      if (d[i -: 3] == p) c = c + 1'b1;
    return c;
  endfunction

  always @(negedge clk) begin
    if (rst && gnt != 2'b00) gcyc_q.push_back(cyc);
    if (rst && done) begin
      exp_t e;
      int   gc;
      ndone++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++; $error("FAIL done_unexpected observed_pending=%0d required>0", exp_q.size());
      end
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        gc = (gcyc_q.size() > 0) ? gcyc_q.pop_front() : -1000;
        checks++;
        assert (done_id === e.id) else begin
          errors++; $error("FAIL done_id observed=%0d expected=%0d", done_id, e.id);
        end
        checks++;
        assert (match_cnt === e.cnt) else begin
          errors++; $error("FAIL match_cnt observed=%0d expected=%0d", match_cnt, e.cnt);
        end
        checks++;
        assert (cyc - gc === WIDTH + 2) else begin
          errors++; $error("FAIL latency observed=%0d expected=%0d", cyc - gc, WIDTH + 2);
        end
      end
      if (chk_period && prev_done >= 0) begin
        checks++;
        assert (cyc - prev_done === WIDTH + 4) else begin
          errors++; $error("FAIL done_period observed=%0d expected=%0d", cyc - prev_done, WIDTH + 4);
        end
      end
      prev_done = cyc;
    end
  end

  task automatic wait_gnt(output logic [1:0] g);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt === 2'b00 && n < 50);
    g = gnt;
  endtask

  task automatic check_gnt(input logic [1:0] g, input logic [1:0] want);
    checks++;
    assert (g === want) else begin
      errors++; $error("FAIL gnt observed=%b expected=%b", g, want);
    end
  endtask

  task automatic push_exp(input logic id, input logic [WIDTH-1:0] d, input logic [2:0] p);
    exp_t e;
    e.id  = id;
    e.cnt = model(d, p);
    exp_q.push_back(e);
  endtask

  task automatic serve(input logic id, input logic [WIDTH-1:0] d, input logic [2:0] p);
    logic [1:0] g;
    if (id) begin data1 = d; pat1 = p; end
    else    begin data0 = d; pat0 = p; end
    push_exp(id, d, p);
    req[id] = 1'b1;
    wait_gnt(g);
    check_gnt(g, id ? 2'b10 : 2'b01);
    req[id] = 1'b0;
  endtask

  task automatic contend(input int n);
    logic [1:0] g;
    req = 2'b11;
    for (int k = 0; k < n; k++) begin
      wait_gnt(g);
      check_gnt(g, k[0] ? 2'b10 : 2'b01);
      if (k == n - 1) req = 2'b00;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    assert (exp_q.size() === 0) else begin
      errors++; $error("FAIL drain_timeout observed_pending=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    gcyc_q.delete();
  endtask

  initial begin
    logic [1:0] g;
    int nd;

    #2 rst = 1'b0;
    #10;
    checks++;
    assert ({gnt, busy, done, done_id, match_cnt, z} === '0) else begin
      errors++; $error("FAIL reset_outputs observed=%b expected=0", {gnt, busy, done, done_id, match_cnt, z});
    end
    @(negedge clk) rst = 1'b1;
    gcyc_q.delete();

    serve(1'b0, 8'b1011_0101, 3'b101); drain();
    serve(1'b0, 8'b1011_0101, 3'b110); drain();
    serve(1'b1, 8'hFF, 3'b111);        drain();

    do_reset();
    data0 = 8'b1011_0101; pat0 = 3'b101;
    data1 = 8'hFF;        pat1 = 3'b111;
    push_exp(1'b0, data0, pat0); push_exp(1'b1, data1, pat1);
    push_exp(1'b0, data0, pat0); push_exp(1'b1, data1, pat1);
    chk_period = 1'b1;
    prev_done  = -1;
    contend(4);
    drain();
    chk_period = 1'b0;

    data0 = 8'b0000_0010; pat0 = 3'b101;
    data1 = 8'b1000_0000; pat1 = 3'b101;
    push_exp(1'b0, data0, pat0); push_exp(1'b1, data1, pat1);
    contend(2);
    drain();

    data0 = 8'hFF; pat0 = 3'b111;
    req[0] = 1'b1;
    wait_gnt(g);
    check_gnt(g, 2'b01);
    req[0] = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    assert ({busy, match_cnt} === {1'b1, 4'd1}) else begin
      errors++; $error("FAIL mid_shift observed=%b expected=%b", {busy, match_cnt}, {1'b1, 4'd1});
    end
    rst = 1'b0;
    #1;
    checks++;
    assert ({gnt, busy, done, match_cnt} === '0) else begin
      errors++; $error("FAIL reset_mid_frame observed=%b expected=0", {gnt, busy, done, match_cnt});
    end
    nd = ndone;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    gcyc_q.delete();
    repeat (15) @(negedge clk);
    checks++;
    assert (ndone === nd) else begin
      errors++; $error("FAIL dropped_frame_done observed=%0d expected=%0d", ndone, nd);
    end
    serve(1'b0, 8'b1101_1011, 3'b011); drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_sched.md
# seq_detect_sched

Round-robin scheduler that shares one programmable 3-bit Moore sequence detector between two requesters. Each requester submits a WIDTH-bit frame and a 3-bit pattern. The block grants one requester at a time, shifts that frame MSB-first through the shared detector, and counts overlapping pattern matches. It reports the count with a one-cycle done pulse, so the detector datapath does not need a private instance per client.

## Interface
- WIDTH, 8, frame length in bits (≥3)
- CNT_W, 4, match counter width; must hold WIDTH-2
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req  in  2  level request per requester; req[i] held until gnt[i]
- data0  in  WIDTH  frame of requester 0, stable while req[0]=1
- data1  in  WIDTH  frame of requester 1, stable while req[1]=1
- pat0  in  3  pattern of requester 0, first bit in [2]
- pat1  in  3  pattern of requester 1, first bit in [2]
- gnt  out  2  one-cycle one-hot grant pulse
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, count valid
- done_id  out  1  requester served, valid with done and held after
- match_cnt  out  CNT_W  matches in the last frame, held until the next LOAD
- z  out  1  detector Moore output, for debug

## Operation
- FSM states: IDLE, LOAD, SHIFT, FLUSH, DONE.
- **IDLE**
  - If no req, stay in IDLE.
  - If any req, arbitrate and go to LOAD.
  - On that edge, capture the winner's data and pattern into shreg and patreg, and record its id in cur_id.
- **Arbitration:** round-robin against last_id.
  - If both requests are high, the requester ≠ last_id wins.
  - If one request is high, it wins.
  - last_id ← cur_id on entry to LOAD.
- **LOAD** (1 cycle)
  - gnt[cur_id]=1.
  - Detector clr=1, so its history and fill count go to 0.
  - match_cnt←0.
  - bit counter←WIDTH-1.
- **SHIFT** (WIDTH cycles)
  - Detector input x=shreg[WIDTH-1].
  - shreg shifts left on every edge.
  - Bit counter decrements; at 0, go to FLUSH.
- **FLUSH** (1 cycle): absorbs the z produced by the last shifted bit.
- **DONE** (1 cycle)
  - done=1 and done_id=cur_id.
  - Return to IDLE. New arbitration is possible on the edge leaving IDLE.
- **Counting:**
  - match_cnt increments on each edge where z=1 and the state is SHIFT or FLUSH.
  - match_cnt saturates at 2^CNT_W-1.
- **Detector** (Moore, overlapping):
  - State is a 3-bit history plus a 2-bit fill count, saturating at 3.
  - z=(fill==3)&&(hist==patreg).
  - z depends only on registered state.
  - Matches never span frames, because LOAD clears the detector.
- req changes during LOAD..DONE are ignored. req must drop after gnt, otherwise the requester is re-served when its turn comes again.

## Timing
- **Reset** (asynchronous assert, synchronous release):
  - state=IDLE, gnt=0, busy=0, done=0, done_id=0, match_cnt=0, z=0.
  - last_id=1, so requester 0 wins the first contention.
- **Reset mid-frame:** the frame is dropped immediately, no done is issued, and the requester must re-request.
- **Latency:** with gnt in cycle T, done is in cycle T+WIDTH+2. Back-to-back service gives a period of WIDTH+4 cycles.
- **Detector output timing:** a bit presented in SHIFT cycle k shows its effect on z in cycle k+1.
- **Simultaneous events:**
  - req and reset arriving together: reset wins.
  - Both req high in IDLE: exactly one gnt bit is set.

## Structure
- Shared package seq_sched_pkg holds:
  - state localparams: IDLE=0, LOAD=1, SHIFT=2, FLUSH=3, DONE=4, in 3 bits;
  - PAT_W=3.
- Sub-module pat3_detect holds the Moore detector.
  - Ports: clk, rst, clr, x, pat[2:0], z.
  - Same reset style as the top level.
- The top level holds the FSM, arbiter, shift register, bit counter and match counter.

## Test plan
- **Basic count:** req[0] with data0=8'b1011_0101, pat0=3'b101 → gnt=2'b01; done 10 cycles later; match_cnt=3, done_id=0.
- **Same frame, other pattern:** data0=8'b1011_0101, pat0=3'b110 → match_cnt=1.
- **Maximum overlap:** data1=8'hFF, pat1=3'b111 → match_cnt=6, done_id=1.
- **Contention from reset:** req=2'b11 held → grants alternate 01, 10, 01, …, each frame is fully served, and the done period is 12 cycles.
- **Reset mid-SHIFT:** assert rst 4 cycles into SHIFT → busy=0, match_cnt=0 and no done. After release, a new request completes normally.
- **Frame isolation:** frame 8'b0000_0010 followed by frame 8'b1000_0000, both with pat 3'b101 → match_cnt=0 for both frames, with no cross-frame match.
